// File: rtl/joy_serial_tx_pkg.sv
// Shared definitions for the joypad serial transmitter and the bus-side controller.
package joy_serial_tx_pkg;
    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, TAIL} joy_state_e;

    localparam int BTN_A   = 7;
    localparam int BTN_B   = 6;
    localparam int BTN_SEL = 5;
    localparam int BTN_ST  = 4;
    localparam int BTN_U   = 3;
    localparam int BTN_D   = 2;
    localparam int BTN_L   = 1;
    localparam int BTN_R   = 0;
endpackage

// File: rtl/joy_in_filter.sv
// Synchronizer chain followed by a stability filter: a new level is accepted
// only after it has been seen for FILT_LEN consecutive clk cycles.
module joy_in_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 3,
    parameter logic IDLE_LVL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             cnt;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {SYNC_STAGES{IDLE_LVL}};
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

    // cnt counts consecutive cycles the synchronized level has differed from dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= IDLE_LVL;
            cnt  <= 3'd0;
        end else if (sync_out == dout) begin
            cnt <= 3'd0;
        end else if (cnt == 3'(FILT_LEN - 1)) begin
            dout <= sync_out;
            cnt  <= 3'd0;
        end else begin
            cnt <= cnt + 3'd1;
        end
    end
endmodule

// File: rtl/joy_serial_tx.sv
// Joypad serial shifter: latches the pad state on the console strobe and
// shifts it out one bit per console read pulse, active-low data.
module joy_serial_tx
    import joy_serial_tx_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 3,
    parameter logic TAIL_BIT    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] buttons,
    input  logic       joy_latch,
    input  logic       joy_clk_n,
    output logic       joy_data_n,
    output logic [7:0] snapshot,
    output logic [3:0] bit_idx
);
    logic [1:0] rst_sync;
    logic       rst_int_n;
    logic       lat_f, rd_f, lat_q, rd_q;
    logic       lat_rise, lat_fall, rd_rise, rd_fall;

    joy_state_e state, state_nxt;
    logic [7:0] shift_reg, shift_nxt, snapshot_nxt;
    logic [3:0] bit_idx_nxt;
    logic       armed, armed_nxt, data_nxt;

    // Assert asynchronously, release on a clk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    joy_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .IDLE_LVL(1'b0)) u_lat_filt (
        .clk(clk), .rst_n(rst_int_n), .din(joy_latch), .dout(lat_f)
    );
    joy_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .IDLE_LVL(1'b1)) u_rd_filt (
        .clk(clk), .rst_n(rst_int_n), .din(joy_clk_n), .dout(rd_f)
    );

    assign lat_rise = lat_f & ~lat_q;
    assign lat_fall = ~lat_f & lat_q;
    assign rd_rise  = rd_f & ~rd_q;
    assign rd_fall  = ~rd_f & rd_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lat_q      <= 1'b0;
            rd_q       <= 1'b1;
            state      <= IDLE;
            shift_reg  <= 8'h00;
            snapshot   <= 8'h00;
            bit_idx    <= 4'd0;
            armed      <= 1'b0;
            joy_data_n <= 1'b1;
        end else begin
            lat_q      <= lat_f;
            rd_q       <= rd_f;
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            snapshot   <= snapshot_nxt;
            bit_idx    <= bit_idx_nxt;
            armed      <= armed_nxt;
            joy_data_n <= data_nxt;
        end
    end

    // armed: a read fall has been seen since the latch fell, so the next rise
    // completes a full pulse and may shift.
    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_reg;
        snapshot_nxt = snapshot;
        bit_idx_nxt  = bit_idx;
        armed_nxt    = armed;
        if (lat_rise) begin
            state_nxt   = LATCH;
            shift_nxt   = buttons;
            bit_idx_nxt = 4'd0;
            armed_nxt   = 1'b0;
        end else begin
            case (state)
                LATCH: begin
                    shift_nxt   = buttons;
                    bit_idx_nxt = 4'd0;
                    armed_nxt   = 1'b0;
                    if (lat_fall) begin
                        snapshot_nxt = buttons;
                        state_nxt    = SHIFT;
                    end
                end
                SHIFT: begin
                    if (rd_fall) armed_nxt = 1'b1;
                    if (rd_rise && armed) begin
                        shift_nxt   = {shift_reg[6:0], TAIL_BIT};
                        bit_idx_nxt = bit_idx + 4'd1;
                        if (bit_idx == 4'd7) state_nxt = TAIL;
                    end
                end
                default: ;
            endcase
        end

        case (state_nxt)
            IDLE:    data_nxt = 1'b1;
            TAIL:    data_nxt = ~TAIL_BIT;
            default: data_nxt = ~shift_nxt[BTN_A];
        endcase
    end
endmodule

// File: tb/tb_joy_serial_tx.sv
// Directed and randomized frames checked against a bit-sequence model of the
// joypad protocol.
module tb_joy_serial_tx;
    localparam logic TAIL = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] buttons = 8'h00;
    logic       joy_latch = 1'b0;
    logic       joy_clk_n = 1'b1;
    logic       joy_data_n;
    logic [7:0] snapshot;
    logic [3:0] bit_idx;

    int checks = 0;
    int errors = 0;

    joy_serial_tx dut (
        .clk(clk), .rst_n(rst_n), .buttons(buttons), .joy_latch(joy_latch),
        .joy_clk_n(joy_clk_n), .joy_data_n(joy_data_n), .snapshot(snapshot),
        .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    // Logical bit presented after n reads of a frame latched with value v.
    function automatic logic exp_bit(input logic [7:0] v, input int n);
        if (n >= 8) return TAIL;
        return v[7 - n];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_pulse();
        joy_clk_n = 1'b0; tick(8);
        joy_clk_n = 1'b1; tick(8);
    endtask

    task automatic latch_pulse(input logic [7:0] v);
        buttons = v;
        joy_latch = 1'b1; tick(8);
        joy_latch = 1'b0; tick(8);
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] v, input int n);
        chk({tag, "_data"}, {7'd0, joy_data_n}, {7'd0, ~exp_bit(v, n)});
        chk({tag, "_idx"}, {4'd0, bit_idx}, (n > 8) ? 8'd8 : 8'(n));
        chk({tag, "_snap"}, snapshot, v);
    endtask

    initial begin
        logic [7:0] v;
        int nr;

        // reset state, including the hold after release
        tick(3);
        chk("rst_data", {7'd0, joy_data_n}, 8'd1);
        chk("rst_snap", snapshot, 8'h00);
        chk("rst_idx", {4'd0, bit_idx}, 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_data", {7'd0, joy_data_n}, 8'd1);
        tick(4);

        // reads in IDLE are ignored
        read_pulse();
        chk("idle_data", {7'd0, joy_data_n}, 8'd1);
        chk("idle_idx", {4'd0, bit_idx}, 8'd0);

        // A5 frame plus tail reads
        latch_pulse(8'hA5);
        chk_frame("a5_0", 8'hA5, 0);
        for (int i = 1; i <= 11; i++) begin
            read_pulse();
            chk_frame($sformatf("a5_%0d", i), 8'hA5, i);
        end

        // latch held high: data follows buttons, reads never shift
        buttons = 8'h80; joy_latch = 1'b1; tick(8);
        chk("hold_d0", {7'd0, joy_data_n}, 8'd0);
        read_pulse(); read_pulse();
        chk("hold_i0", {4'd0, bit_idx}, 8'd0);
        buttons = 8'h00; tick(2);
        chk("hold_d1", {7'd0, joy_data_n}, 8'd1);
        read_pulse(); read_pulse();
        chk("hold_d2", {7'd0, joy_data_n}, 8'd1);
        chk("hold_i1", {4'd0, bit_idx}, 8'd0);
        joy_latch = 1'b0; tick(8);

        // aborted frame then new frame with 01
        latch_pulse(8'h3C);
        repeat (3) read_pulse();
        chk_frame("abt_3", 8'h3C, 3);
        latch_pulse(8'h01);
        chk_frame("new_0", 8'h01, 0);
        for (int i = 1; i <= 8; i++) begin
            read_pulse();
            chk_frame($sformatf("new_%0d", i), 8'h01, i);
        end

        // read line low while latch falls: that rise is not counted
        buttons = 8'hC3; joy_latch = 1'b1; tick(8);
        joy_clk_n = 1'b0; tick(2);
        joy_latch = 1'b0; tick(8);
        joy_clk_n = 1'b1; tick(8);
        chk_frame("lowfall_0", 8'hC3, 0);
        read_pulse();
        chk_frame("lowfall_1", 8'hC3, 1);

        // 1-cycle glitch on the read line is filtered out
        read_pulse();
        joy_clk_n = 1'b0; tick(1); joy_clk_n = 1'b1; tick(8);
        chk_frame("glitch", 8'hC3, 2);

        // latch rise together with a read rise: latch wins
        joy_clk_n = 1'b0; tick(8);
        buttons = 8'h5A;
        joy_latch = 1'b1; joy_clk_n = 1'b1; tick(8);
        chk("coin_idx", {4'd0, bit_idx}, 8'd0);
        chk("coin_data", {7'd0, joy_data_n}, 8'd1);
        buttons = 8'hA5; tick(2);
        chk("coin_latch", {7'd0, joy_data_n}, 8'd0);
        joy_latch = 1'b0; tick(8);

        // reset mid-shift
        latch_pulse(8'hF0);
        repeat (4) read_pulse();
        chk_frame("prerst", 8'hF0, 4);
        rst_n = 1'b0; #1;
        chk("mrst_data", {7'd0, joy_data_n}, 8'd1);
        chk("mrst_snap", snapshot, 8'h00);
        chk("mrst_idx", {4'd0, bit_idx}, 8'd0);
        tick(2); rst_n = 1'b1; tick(4);
        read_pulse(); read_pulse();
        chk("post_data", {7'd0, joy_data_n}, 8'd1);
        chk("post_idx", {4'd0, bit_idx}, 8'd0);
        chk("post_snap", snapshot, 8'h00);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            v = 8'($urandom);
            nr = $urandom_range(0, 11);
            latch_pulse(v);
            chk_frame($sformatf("rnd%0d_0", f), v, 0);
            for (int i = 1; i <= nr; i++) read_pulse();
            chk_frame($sformatf("rnd%0d_%0d", f, nr), v, nr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
